// File: rtl/memory_pkg.sv
// Shared types and defaults for the button-driven memory bank controller.
// Holds the controller state encoding and the button index map.
package memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  // Bit positions of each button inside the packed press vector
  localparam int BTN_CLEAR  = 0;
  localparam int BTN_WRITE  = 1;
  localparam int BTN_READ   = 2;
  localparam int BTN_TOGGLE = 3;
  localparam int BTN_COUNT  = 4;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for an active-low push-button plus a one-cycle
// press pulse on the synchronised falling edge of the raw input.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_n,
  output logic o_press
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= ~i_btn_n;
      r_s2 <= r_s1;
    end
  end

  assign o_press = r_s1 & ~r_s2;

endmodule

// File: rtl/memory_bank_ctrl.sv
// Register-file controller driven by four push-buttons: write, read,
// auto-scan display and a multi-cycle clear-all, with a write-confirm blink.
module memory_bank_ctrl
  import memory_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SCAN_DIV  = 25000000,
  parameter int BLINK_CYC = 12500000,
  parameter int BLINK_N   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] value,
  input  logic [ADDR_W-1:0] addr,
  input  logic              w_button1,
  input  logic              w_button2,
  input  logic              w_button3,
  input  logic              w_button4,
  output logic [DATA_W-1:0] led,
  output logic [ADDR_W-1:0] disp_addr,
  output logic              scan_active,
  output logic              busy
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BSUB_W = $clog2(BLINK_CYC + 1);
  localparam int BPH_W  = $clog2(2 * BLINK_N + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [BSUB_W-1:0] BSUB_LAST = BSUB_W'(BLINK_CYC - 1);
  localparam logic [BPH_W-1:0]  BPH_LAST  = BPH_W'(2 * BLINK_N - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [BTN_COUNT-1:0] w_raw_n;
  logic [BTN_COUNT-1:0] w_press;

  assign w_raw_n = {w_button4, w_button3, w_button2, w_button1};

  for (genvar gi = 0; gi < BTN_COUNT; gi++) begin : g_btn
    btn_edge u_btn (
      .clk     (clk),
      .rst_n   (reset),
      .i_btn_n (w_raw_n[gi]),
      .o_press (w_press[gi])
    );
  end

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic [DATA_W-1:0] r_disp_data;
  logic [ADDR_W-1:0] r_disp_addr;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [DIV_W-1:0]  r_div;
  logic              r_blink_on;
  logic [BSUB_W-1:0] r_blink_sub;
  logic [BPH_W-1:0]  r_blink_ph;

  logic              w_clr;
  logic              w_wr;
  logic              w_rd;
  logic              w_tog;
  logic              w_step;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_clr       = w_press[BTN_CLEAR];
  assign w_wr        = w_press[BTN_WRITE];
  assign w_rd        = w_press[BTN_READ];
  assign w_tog       = w_press[BTN_TOGGLE];
  assign w_next_addr = r_disp_addr + 1'b1;
  // A read in the same cycle as the scan terminal count suppresses the step
  assign w_step      = (r_state == ST_SCAN) && (r_div == DIV_LAST) && !w_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state     <= ST_IDLE;
      r_disp_data <= '0;
      r_disp_addr <= '0;
      r_clr_ptr   <= '0;
      r_div       <= '0;
      r_blink_on  <= 1'b0;
      r_blink_sub <= '0;
      r_blink_ph  <= '0;
    end else begin
      if (r_blink_on) begin
        if (r_blink_sub == BSUB_LAST) begin
          r_blink_sub <= '0;
          if (r_blink_ph == BPH_LAST) r_blink_on <= 1'b0;
          else                        r_blink_ph <= r_blink_ph + 1'b1;
        end else begin
          r_blink_sub <= r_blink_sub + 1'b1;
        end
      end

      case (r_state)
        ST_CLEAR: begin
          r_mem[r_clr_ptr] <= '0;
          r_clr_ptr        <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == ADDR_LAST) r_state <= ST_IDLE;
        end

        default: begin
          if (w_clr) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= '0;
            r_disp_data <= '0;
            r_disp_addr <= '0;
            r_blink_on  <= 1'b0;
            r_blink_sub <= '0;
            r_blink_ph  <= '0;
          end else begin
            // Later assignments to disp_data override earlier ones by priority
            if (r_state == ST_SCAN) begin
              if (w_rd || r_div == DIV_LAST) r_div <= '0;
              else                           r_div <= r_div + 1'b1;
              if (w_step) begin
                r_disp_addr <= w_next_addr;
                r_disp_data <= (w_wr && addr == w_next_addr) ? value : r_mem[w_next_addr];
              end
            end

            if (w_wr) begin
              r_mem[addr] <= value;
              if (addr == r_disp_addr && !w_step) r_disp_data <= value;
              r_blink_on  <= 1'b1;
              r_blink_sub <= '0;
              r_blink_ph  <= '0;
            end

            if (w_rd) begin
              r_disp_addr <= addr;
              r_disp_data <= w_wr ? value : r_mem[addr];
            end

            if (w_tog) begin
              r_state <= (r_state == ST_SCAN) ? ST_IDLE : ST_SCAN;
              r_div   <= '0;
            end
          end
        end
      endcase
    end
  end

  // Even blink phases are the dark ones
  assign led         = (r_blink_on && !r_blink_ph[0]) ? '0 : r_disp_data;
  assign disp_addr   = r_disp_addr;
  assign scan_active = (r_state == ST_SCAN);
  assign busy        = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_memory_bank_ctrl.sv
// Directed bench for memory_bank_ctrl with small scan/blink timings.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_memory_bank_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] value = 8'h00;
  logic [2:0] addr = 3'd0;
  logic       b1 = 1'b1;
  logic       b2 = 1'b1;
  logic       b3 = 1'b1;
  logic       b4 = 1'b1;
  logic [7:0] led;
  logic [2:0] disp_addr;
  logic       scan_active;
  logic       busy;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] P_CLR = 4'b0001;
  localparam logic [3:0] P_WR  = 4'b0010;
  localparam logic [3:0] P_RD  = 4'b0100;
  localparam logic [3:0] P_TOG = 4'b1000;

  memory_bank_ctrl #(
    .DATA_W(8), .ADDR_W(3), .SCAN_DIV(4), .BLINK_CYC(2), .BLINK_N(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .addr        (addr),
    .w_button1   (b1),
    .w_button2   (b2),
    .w_button3   (b3),
    .w_button4   (b4),
    .led         (led),
    .disp_addr   (disp_addr),
    .scan_active (scan_active),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Buttons low for one cycle; returns on the falling edge just after the
  // rising edge at which the controller acts on the press.
  task automatic press(input logic [3:0] m);
    b1 = ~m[0];
    b2 = ~m[1];
    b3 = ~m[2];
    b4 = ~m[3];
    @(negedge clk);
    b1 = 1'b1;
    b2 = 1'b1;
    b3 = 1'b1;
    b4 = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    addr  = a;
    value = v;
    press(P_WR);
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr = a;
    press(P_RD);
    chk(tag, {24'd0, led}, {24'd0, exp});
  endtask

  logic [7:0] blink_exp [9];

  initial begin
    // Reset state
    #1 reset = 1'b0;
    tick(2);
    chk("rst_led", {24'd0, led}, 32'h0);
    chk("rst_addr", {29'd0, disp_addr}, 32'h0);
    chk("rst_scan", {31'd0, scan_active}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b1;
    tick(1);

    // 1: write A5 to addr 3 while displaying addr 0, then read it back
    wr(3'd3, 8'hA5);
    chk("wr1_led_dark", {24'd0, led}, 32'h0);
    tick(10);
    rd_chk("rd3_led", 3'd3, 8'hA5);
    chk("rd3_addr", {29'd0, disp_addr}, 32'h3);

    // 2: write-through to displayed addr with a visible blink pattern
    blink_exp = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'h00, 8'h00, 8'h3C, 8'h3C, 8'h3C};
    wr(3'd3, 8'h3C);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("blink_%0d", k), {24'd0, led}, {24'd0, blink_exp[k]});
      tick(1);
    end
    addr  = 3'd5;
    value = 8'h77;
    press(P_WR | P_RD);
    chk("wrrd_restart_dark", {24'd0, led}, 32'h0);
    tick(8);
    chk("wrrd_led", {24'd0, led}, 32'h77);
    chk("wrrd_addr", {29'd0, disp_addr}, 32'h5);

    // 3: scan through mem[i] = i + 10
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
    tick(10);
    rd_chk("scan_pre_led", 3'd0, 8'h10);
    press(P_TOG);
    chk("scan_on", {31'd0, scan_active}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      tick(4);
      chk($sformatf("scan_addr_%0d", k), {29'd0, disp_addr}, 32'(k % 8));
      chk($sformatf("scan_led_%0d", k), {24'd0, led}, 32'(8'h10 + (k % 8)));
    end
    press(P_TOG);
    tick(10);
    chk("scan_off", {31'd0, scan_active}, 32'h0);
    chk("scan_frozen_addr", {29'd0, disp_addr}, 32'h0);
    chk("scan_frozen_led", {24'd0, led}, 32'h10);

    // 4: clear-all after filling with FF; a write while busy is dropped
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    tick(10);
    press(P_CLR);
    chk("clr_busy_0", {31'd0, busy}, 32'h1);
    chk("clr_led", {24'd0, led}, 32'h0);
    wr(3'd0, 8'h55);
    chk("clr_busy_2", {31'd0, busy}, 32'h1);
    tick(5);
    chk("clr_busy_7", {31'd0, busy}, 32'h1);
    tick(1);
    chk("clr_busy_8", {31'd0, busy}, 32'h0);
    for (int i = 0; i < 8; i++) rd_chk($sformatf("clr_mem_%0d", i), 3'(i), 8'h00);

    // 5: clear and write pressed together
    wr(3'd1, 8'hFF);
    tick(10);
    addr  = 3'd6;
    value = 8'hAB;
    press(P_CLR | P_WR);
    chk("prio_busy", {31'd0, busy}, 32'h1);
    tick(9);
    chk("prio_idle", {31'd0, busy}, 32'h0);
    rd_chk("prio_mem6", 3'd6, 8'h00);
    rd_chk("prio_mem1", 3'd1, 8'h00);

    // 6: asynchronous reset while scanning and blinking
    wr(3'd4, 8'h99);
    tick(10);
    rd_chk("ar_pre_led", 3'd4, 8'h99);
    press(P_TOG);
    tick(2);
    wr(3'd5, 8'h12);
    tick(2);
    chk("ar_step_led", {24'd0, led}, 32'h12);
    chk("ar_step_addr", {29'd0, disp_addr}, 32'h5);
    #2 reset = 1'b0;
    #1;
    chk("ar_led", {24'd0, led}, 32'h0);
    chk("ar_addr", {29'd0, disp_addr}, 32'h0);
    chk("ar_scan", {31'd0, scan_active}, 32'h0);
    chk("ar_busy", {31'd0, busy}, 32'h0);
    tick(2);
    reset = 1'b1;
    tick(1);
    rd_chk("ar_mem4", 3'd4, 8'h00);
    rd_chk("ar_mem5", 3'd5, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_bank_ctrl.md
Name: memory_bank_ctrl

Overview:
- Parametrised, button-driven register-file controller for the board memory lessons.
- Stores 2^ADDR_W words of DATA_W bits. Write/read/mode/clear commands come from raw active-low push-buttons, edge-detected internally.
- Drives a display word with write-confirm blink, an auto-scan mode that walks all addresses, and a multi-cycle clear-all.
- Top level feeds led/disp_addr into existing hex2seven_seg instances.

Parameters:
- DATA_W, 8, word width.
- ADDR_W, 3, address width; DEPTH = 2^ADDR_W.
- SCAN_DIV, 25000000, clk cycles per scan step (>=2).
- BLINK_CYC, 12500000, clk cycles per blink half-period (>=1).
- BLINK_N, 3, number of off-phases after a write (>=1).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- value  in  DATA_W  write data
- addr  in  ADDR_W  write/read address
- w_button1  in  1  raw clear-all button, active-low
- w_button2  in  1  raw write button, active-low
- w_button3  in  1  raw read button, active-low
- w_button4  in  1  raw scan-mode toggle, active-low
- led  out  DATA_W  displayed word (blanked to 0 during blink off-phase)
- disp_addr  out  ADDR_W  address of displayed word
- scan_active  out  1  high in SCAN state
- busy  out  1  high in CLEAR state

Behaviour:
- Reset (async, active-low): all mem words, disp_data, disp_addr, sync flops, counters = 0; state IDLE; led=0, disp_addr=0, scan_active=0, busy=0.
- Edge detect, per button:
  - s1 <= ~raw; s2 <= s1; press = s1 & ~s2.
  - Raw low before edge N -> press high in cycle N..N+1 -> action registered at edge N+1.
  - Exactly one pulse per press; release produces nothing. No debounce (bounce = multiple presses).
- States: IDLE, SCAN, CLEAR. Priority within a cycle: clear > write > read > toggle.
- Clear press (IDLE/SCAN):
  - Enter CLEAR; busy=1; clr_ptr=0.
  - Each cycle mem[clr_ptr]<=0, clr_ptr++. After writing DEPTH-1, go to IDLE, busy=0.
  - Total DEPTH cycles in CLEAR. At entry: disp_data=0, disp_addr=0, blink cancelled.
  - All other presses while busy are ignored (dropped, not queued).
- Write press (IDLE/SCAN):
  - mem[addr]<=value.
  - If addr==disp_addr, disp_data<=value (write-through).
  - Start blink: 2*BLINK_N*BLINK_CYC cycles. Phase k (length BLINK_CYC) is off for even k, starting k=0. led=0 when off, else disp_data.
  - A new write restarts the blink from phase 0.
- Read press (IDLE/SCAN):
  - disp_addr<=addr; disp_data<=mem[addr].
  - Simultaneous write, same addr: disp_data<=value (write-first).
  - In SCAN, also reset divider to 0.
- Toggle press:
  - IDLE->SCAN (divider=0); SCAN->IDLE (disp_addr/disp_data hold).
- SCAN stepping:
  - Divider counts 0..SCAN_DIV-1. On terminal count: disp_addr<=disp_addr+1 (wraps DEPTH-1->0), disp_data<=mem[disp_addr+1].
  - Write to that next address in the same cycle: use value.
  - Read press in the same cycle as terminal count: read wins, no step.
- IDLE: disp_data is a snapshot; it changes only on read, write-through, or clear.
- Blink continues across IDLE<->SCAN transitions.
- Reset asserted mid-CLEAR or mid-blink: immediate full reset, IDLE.
- Address arithmetic is modulo DEPTH; no out-of-range possible.

Decomposition:
- Shared package memory_pkg: state encoding (ST_IDLE, ST_SCAN, ST_CLEAR), default widths.
- One sub-module btn_edge (2-flop sync + press pulse; async active-low reset), instantiated 4x.
- Storage stays in-module as a register array; no RAM inference needed.

Test Plan:
All scenarios use DATA_W=8, ADDR_W=3, SCAN_DIV=4, BLINK_CYC=2, BLINK_N=2.
1. Write/read and blink:
   - Reset. value=8'hA5, addr=3, pulse w_button2 low one cycle -> mem[3]=A5 on the 2nd edge.
   - Blink spans 8 cycles: led=0 for 2 cycles, then disp_data for 2, repeated twice.
   - Then read addr=3 -> led=A5, disp_addr=3.
2. Write-through and read-first-vs-write:
   - Display at addr 3; write 8'h3C to addr 3 -> led=3C after blink, no read needed.
   - Simultaneous write addr=5 value=77 with read addr=5 -> led=77.
3. Scan:
   - mem[i]=i+8'h10. Toggle -> scan_active=1.
   - disp_addr steps 0,1,...,7,0 every 4 cycles; led tracks 10..17,10.
   - Toggle again -> disp_addr freezes.
4. Clear:
   - Fill all 8 words with FF; press clear -> busy=1 for exactly 8 cycles, then 0.
   - All words read 00, led=00.
   - Write press during busy -> ignored (mem unchanged).
5. Priority:
   - Clear and write pressed same cycle -> CLEAR entered, write dropped, all words 00.
6. Async reset mid-scan/mid-blink:
   - Assert reset between clock edges -> led, disp_addr, scan_active, busy go 0 immediately.
   - After release, mem contents read 00.
